// File: rtl/pe_dbw_pkg.sv
// Shared constants and arithmetic helpers for the double-buffered-weight
// processing element.
package pe_pkg;

  localparam int PE_DATA_W   = 8;
  localparam int PE_WEIGHT_W = 8;
  localparam int PE_ACC_W    = 24;

  typedef struct packed {
    logic [63:0] sum;
    logic        ovf;
  } sat_res_t;

  // Operands must already be sign-extended and lie within the signed
  // range of 'width' bits. The 64-bit sum therefore cannot wrap.
  function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                       input logic signed [63:0] b,
                                       input int                 width,
                                       input logic               saturate);
    sat_res_t          r;
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s     = a + b;
    hi    = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo    = -hi - 64'sd1;
    r.ovf = (s > hi) || (s < lo);
    if (r.ovf && saturate) r.sum = (s > hi) ? hi : lo;
    else                   r.sum = s;
    return r;
  endfunction

endpackage

// File: rtl/pe_dbw_if.sv
// Neighbour-facing bus of one processing element: activation, partial sum,
// weight shift chain and the strobes that ripple through the array.
interface pe_dbw_if
  import pe_pkg::*;
#(
  parameter int DATA_W   = PE_DATA_W,
  parameter int WEIGHT_W = PE_WEIGHT_W,
  parameter int ACC_W    = PE_ACC_W
);
  // There is no valid/ready pair: 'active' qualifies datain/sumin on each
  // edge and, when low, freezes the MAC path without any loss or repeat.
  logic                active;
  logic [DATA_W-1:0]   datain;
  logic [WEIGHT_W-1:0] win;
  logic                wwrite;
  logic                wswap;
  logic [ACC_W-1:0]    sumin;
  logic                ovf_clr;
  logic [ACC_W-1:0]    maccout;
  logic [DATA_W-1:0]   dataout;
  logic [WEIGHT_W-1:0] wout;
  logic                wwriteout;
  logic                wswapout;
  logic                activeout;
  logic                ovf;

  modport master (
    output active, datain, win, wwrite, wswap, sumin, ovf_clr,
    input  maccout, dataout, wout, wwriteout, wswapout, activeout, ovf
  );

  modport slave (
    input  active, datain, win, wwrite, wswap, sumin, ovf_clr,
    output maccout, dataout, wout, wwriteout, wswapout, activeout, ovf
  );

endinterface

// File: rtl/pe_dbw_mac_pipe.sv
// Signed multiply-accumulate with MULT_LAT enable-gated register stages;
// the operands (and thus the weight) are frozen at issue.
module pe_mac_pipe
  import pe_pkg::*;
#(
  parameter int DATA_W   = PE_DATA_W,
  parameter int WEIGHT_W = PE_WEIGHT_W,
  parameter int ACC_W    = PE_ACC_W,
  parameter int MULT_LAT = 1,
  parameter int SATURATE = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       en,
  input  logic signed [DATA_W-1:0]   data,
  input  logic signed [WEIGHT_W-1:0] weight,
  input  logic signed [ACC_W-1:0]    sum_in,
  output logic signed [ACC_W-1:0]    sum_out,
  output logic                       ovf_hit
);

  localparam int PROD_W = DATA_W + WEIGHT_W;

  logic signed [DATA_W-1:0]   a_d;
  logic signed [WEIGHT_W-1:0] a_w;
  logic signed [ACC_W-1:0]    a_s;
  logic signed [PROD_W-1:0]   prod;
  logic signed [PROD_W-1:0]   b_p;
  logic signed [ACC_W-1:0]    b_s;
  sat_res_t                   res;
  logic                       sum_unused;

  generate
    if (MULT_LAT >= 2) begin : g_op_reg
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          a_d <= '0;
          a_w <= '0;
          a_s <= '0;
        end else if (en) begin
          a_d <= data;
          a_w <= weight;
          a_s <= sum_in;
        end
      end
    end else begin : g_op_comb
      assign a_d = data;
      assign a_w = weight;
      assign a_s = sum_in;
    end
  endgenerate

  assign prod = PROD_W'(a_d) * PROD_W'(a_w);

  // Depth 3 splits the multiplier from the adder.
  generate
    if (MULT_LAT == 3) begin : g_prod_reg
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          b_p <= '0;
          b_s <= '0;
        end else if (en) begin
          b_p <= prod;
          b_s <= a_s;
        end
      end
    end else begin : g_prod_comb
      assign b_p = prod;
      assign b_s = a_s;
    end
  endgenerate

  always_comb res = sat_add(64'(b_p), 64'(b_s), ACC_W, SATURATE != 0);

  assign sum_unused = ^res.sum[63:ACC_W];
  assign ovf_hit    = en & res.ovf;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)   sum_out <= '0;
    else if (en) sum_out <= res.sum[ACC_W-1:0];
  end

endmodule

// File: rtl/pe_dbw.sv
// One tile of the systolic matrix-multiply array: double-buffered weight,
// pipelined saturating MAC, and the registered pass-through to neighbours.
module pe_dbw
  import pe_pkg::*;
#(
  parameter int DATA_W   = PE_DATA_W,
  parameter int WEIGHT_W = PE_WEIGHT_W,
  parameter int ACC_W    = PE_ACC_W,
  parameter int MULT_LAT = 1,
  parameter int SATURATE = 1
) (
  input  logic    clock,
  input  logic    reset,
  pe_dbw_if.slave bus
);

  generate
    if (ACC_W < DATA_W + WEIGHT_W || ACC_W > 62) begin : g_bad_acc_w
      $error("pe_dbw: ACC_W must lie in DATA_W+WEIGHT_W .. 62");
    end
    if (MULT_LAT < 1 || MULT_LAT > 3) begin : g_bad_mult_lat
      $error("pe_dbw: MULT_LAT must be 1, 2 or 3");
    end
  endgenerate

  logic [WEIGHT_W-1:0] shadow_w;
  logic [WEIGHT_W-1:0] active_w;
  logic [ACC_W-1:0]    mac_sum;
  logic                ovf_hit;

  pe_mac_pipe #(
    .DATA_W   (DATA_W),
    .WEIGHT_W (WEIGHT_W),
    .ACC_W    (ACC_W),
    .MULT_LAT (MULT_LAT),
    .SATURATE (SATURATE)
  ) u_mac (
    .clock   (clock),
    .reset   (reset),
    .en      (bus.active),
    .data    (bus.datain),
    .weight  (active_w),
    .sum_in  (bus.sumin),
    .sum_out (mac_sum),
    .ovf_hit (ovf_hit)
  );

  assign bus.maccout = mac_sum;

  // Weight chain and swap run regardless of 'active'. A same-edge write
  // and swap hands the pre-write shadow to the active weight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow_w      <= '0;
      active_w      <= '0;
      bus.wout      <= '0;
      bus.wwriteout <= 1'b0;
      bus.wswapout  <= 1'b0;
      bus.activeout <= 1'b0;
      bus.dataout   <= '0;
      bus.ovf       <= 1'b0;
    end else begin
      bus.wwriteout <= bus.wwrite;
      bus.wswapout  <= bus.wswap;
      bus.activeout <= bus.active;
      if (bus.wwrite) begin
        shadow_w <= bus.win;
        bus.wout <= shadow_w;
      end else begin
        bus.wout <= '0;
      end
      if (bus.wswap)  active_w    <= shadow_w;
      if (bus.active) bus.dataout <= bus.datain;
      if (ovf_hit)          bus.ovf <= 1'b1;
      else if (bus.ovf_clr) bus.ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pe_dbw.sv
// Self-checking bench for pe_dbw: five instances (latency 1/2/3 at 24 bits,
// saturating and wrapping at 16 bits) share one stimulus stream.
module tb_pe_dbw;

  logic        clock = 1'b0;
  logic        reset;
  logic        active, wwrite, wswap, ovf_clr;
  logic [7:0]  datain, win;
  logic [23:0] sumin;

  always #5 clock = ~clock;

  pe_dbw_if #(.DATA_W(8), .WEIGHT_W(8), .ACC_W(24)) if_l1 (), if_l2 (), if_l3 ();
  pe_dbw_if #(.DATA_W(8), .WEIGHT_W(8), .ACC_W(16)) if_s (), if_w ();

  assign {if_l1.active, if_l1.datain, if_l1.win, if_l1.wwrite, if_l1.wswap, if_l1.sumin, if_l1.ovf_clr} =
         {active, datain, win, wwrite, wswap, sumin, ovf_clr};
  assign {if_l2.active, if_l2.datain, if_l2.win, if_l2.wwrite, if_l2.wswap, if_l2.sumin, if_l2.ovf_clr} =
         {active, datain, win, wwrite, wswap, sumin, ovf_clr};
  assign {if_l3.active, if_l3.datain, if_l3.win, if_l3.wwrite, if_l3.wswap, if_l3.sumin, if_l3.ovf_clr} =
         {active, datain, win, wwrite, wswap, sumin, ovf_clr};
  assign {if_s.active, if_s.datain, if_s.win, if_s.wwrite, if_s.wswap, if_s.sumin, if_s.ovf_clr} =
         {active, datain, win, wwrite, wswap, sumin[15:0], ovf_clr};
  assign {if_w.active, if_w.datain, if_w.win, if_w.wwrite, if_w.wswap, if_w.sumin, if_w.ovf_clr} =
         {active, datain, win, wwrite, wswap, sumin[15:0], ovf_clr};

  pe_dbw #(.DATA_W(8), .WEIGHT_W(8), .ACC_W(24), .MULT_LAT(1), .SATURATE(1))
    dut_l1 (.clock(clock), .reset(reset), .bus(if_l1));
  pe_dbw #(.DATA_W(8), .WEIGHT_W(8), .ACC_W(24), .MULT_LAT(2), .SATURATE(1))
    dut_l2 (.clock(clock), .reset(reset), .bus(if_l2));
  pe_dbw #(.DATA_W(8), .WEIGHT_W(8), .ACC_W(24), .MULT_LAT(3), .SATURATE(1))
    dut_l3 (.clock(clock), .reset(reset), .bus(if_l3));
  pe_dbw #(.DATA_W(8), .WEIGHT_W(8), .ACC_W(16), .MULT_LAT(1), .SATURATE(1))
    dut_s (.clock(clock), .reset(reset), .bus(if_s));
  pe_dbw #(.DATA_W(8), .WEIGHT_W(8), .ACC_W(16), .MULT_LAT(1), .SATURATE(0))
    dut_w (.clock(clock), .reset(reset), .bus(if_w));

  // Reference model state
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  m_shadow, m_aw, m_dout;
  logic        m_ovf1, m_ovf_s, m_ovf_w;
  logic [23:0] h1, h2, h3;
  logic [15:0] h_s, h_w;
  logic [23:0] exp_q1[$];
  logic [23:0] exp_q2[$];
  logic [23:0] exp_q3[$];

  typedef struct {
    logic [7:0]  d;
    logic [7:0]  w;
    logic [23:0] s;
    logic [15:0] exp_sat;
    logic [15:0] exp_wrap;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] mac_model(input logic [7:0] d, input logic [7:0] w,
                                            input logic [23:0] s, input int accw,
                                            input bit sat, output bit ovf);
    longint sx, full, hi, lo, r;
    sx   = (accw == 16) ? longint'($signed(s[15:0])) : longint'($signed(s));
    full = sx + longint'($signed(d)) * longint'($signed(w));
    hi   = (longint'(1) << (accw - 1)) - 1;
    lo   = -hi - 1;
    ovf  = (full > hi) || (full < lo);
    r    = (ovf && sat) ? ((full > hi) ? hi : lo) : full;
    return r[23:0];
  endfunction

  task automatic model_init();
    m_shadow = '0; m_aw = '0; m_dout = '0;
    m_ovf1 = 1'b0; m_ovf_s = 1'b0; m_ovf_w = 1'b0;
    h1 = '0; h2 = '0; h3 = '0; h_s = '0; h_w = '0;
    exp_q1.delete(); exp_q2.delete(); exp_q3.delete();
    // Deeper pipelines first emit the zero results held in their reset stages.
    exp_q2.push_back(24'h0);
    exp_q3.push_back(24'h0);
    exp_q3.push_back(24'h0);
  endtask

  // One clock edge: drive, update model, then compare 1 ns after the edge.
  task automatic step(input logic act, input logic [7:0] d, input logic [23:0] s,
                      input logic ww, input logic [7:0] wi, input logic sw, input logic clr);
    logic [23:0] e24, es, ew;
    logic [7:0]  e_wout;
    bit          o24, os, ow;
    active = act; datain = d; sumin = s; wwrite = ww; win = wi; wswap = sw; ovf_clr = clr;
    e24    = mac_model(d, m_aw, s, 24, 1'b1, o24);
    es     = mac_model(d, m_aw, s, 16, 1'b1, os);
    ew     = mac_model(d, m_aw, s, 16, 1'b0, ow);
    e_wout = ww ? m_shadow : 8'h00;
    if (act) begin
      exp_q1.push_back(e24); exp_q2.push_back(e24); exp_q3.push_back(e24);
      h_s = es[15:0]; h_w = ew[15:0]; m_dout = d;
    end
    if (act && o24) m_ovf1  = 1'b1; else if (clr) m_ovf1  = 1'b0;
    if (act && os)  m_ovf_s = 1'b1; else if (clr) m_ovf_s = 1'b0;
    if (act && ow)  m_ovf_w = 1'b1; else if (clr) m_ovf_w = 1'b0;
    if (sw) m_aw = m_shadow;
    if (ww) m_shadow = wi;
    @(posedge clock);
    #1;
    if (act) begin
      h1 = exp_q1.pop_front(); h2 = exp_q2.pop_front(); h3 = exp_q3.pop_front();
    end
    check("mac_l1", if_l1.maccout, h1);
    check("mac_l2", if_l2.maccout, h2);
    check("mac_l3", if_l3.maccout, h3);
    check("mac_sat16", 24'(if_s.maccout), 24'(h_s));
    check("mac_wrap16", 24'(if_w.maccout), 24'(h_w));
    check("ovf_l1", 24'(if_l1.ovf), 24'(m_ovf1));
    check("ovf_sat16", 24'(if_s.ovf), 24'(m_ovf_s));
    check("ovf_wrap16", 24'(if_w.ovf), 24'(m_ovf_w));
    check("dataout_l1", 24'(if_l1.dataout), 24'(m_dout));
    check("dataout_l3", 24'(if_l3.dataout), 24'(m_dout));
    check("wout", 24'(if_l1.wout), 24'(e_wout));
    check("wwriteout", 24'(if_l1.wwriteout), 24'(ww));
    check("wswapout", 24'(if_l1.wswapout), 24'(sw));
    check("activeout", 24'(if_l1.activeout), 24'(act));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mac_l1"}, if_l1.maccout, 24'h0);
    check({tag, "_mac_l2"}, if_l2.maccout, 24'h0);
    check({tag, "_mac_l3"}, if_l3.maccout, 24'h0);
    check({tag, "_mac_s16"}, 24'(if_s.maccout), 24'h0);
    check({tag, "_mac_w16"}, 24'(if_w.maccout), 24'h0);
    check({tag, "_dataout"}, 24'(if_l1.dataout), 24'h0);
    check({tag, "_wout"}, 24'(if_l1.wout), 24'h0);
    check({tag, "_wwriteout"}, 24'(if_l1.wwriteout), 24'h0);
    check({tag, "_wswapout"}, 24'(if_l1.wswapout), 24'h0);
    check({tag, "_activeout"}, 24'(if_l1.activeout), 24'h0);
    check({tag, "_ovf_l1"}, 24'(if_l1.ovf), 24'h0);
    check({tag, "_ovf_s16"}, 24'(if_s.ovf), 24'h0);
    check({tag, "_ovf_w16"}, 24'(if_w.ovf), 24'h0);
  endtask

  // Single issue followed by zero bubbles; result must appear exactly at
  // edge MULT_LAT on each latency variant.
  task automatic shot(input logic [7:0] d, input logic [23:0] s, input logic [23:0] exp);
    step(1'b1, d, s, 1'b0, 8'h0, 1'b0, 1'b0);
    check("shot_e1_l1", if_l1.maccout, exp);
    check("shot_e1_l2", if_l2.maccout, 24'h0);
    check("shot_e1_l3", if_l3.maccout, 24'h0);
    check("shot_e1_dout_l3", 24'(if_l3.dataout), 24'(d));
    step(1'b1, 8'h0, 24'h0, 1'b0, 8'h0, 1'b0, 1'b0);
    check("shot_e2_l2", if_l2.maccout, exp);
    check("shot_e2_l3", if_l3.maccout, 24'h0);
    step(1'b1, 8'h0, 24'h0, 1'b0, 8'h0, 1'b0, 1'b0);
    check("shot_e3_l3", if_l3.maccout, exp);
  endtask

  task automatic rand_step();
    logic [31:0] r;
    r = $urandom;
    step($urandom_range(0, 3) != 0, 8'($urandom), {{3{r[20]}}, r[20:0]},
         $urandom_range(0, 9) < 3, 8'($urandom), $urandom_range(0, 9) == 0,
         $urandom_range(0, 9) == 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h03, 8'h07, 24'h00000A, 16'h001F, 16'h001F, 1'b0};
    vecs[1] = '{8'h80, 8'h80, 24'h007FFF, 16'h7FFF, 16'hBFFF, 1'b1};
    vecs[2] = '{8'h7F, 8'h80, 24'hFF8000, 16'h8000, 16'h4080, 1'b1};
    vecs[3] = '{8'hFF, 8'hFF, 24'h007FFE, 16'h7FFF, 16'h7FFF, 1'b0};
    vecs[4] = '{8'h01, 8'hFF, 24'hFF8001, 16'h8000, 16'h8000, 1'b0};
    vecs[5] = '{8'h01, 8'h01, 24'h007FFF, 16'h7FFF, 16'h8000, 1'b1};
    vecs[6] = '{8'h00, 8'h80, 24'hFFFFFB, 16'hFFFB, 16'hFFFB, 1'b0};
    vecs[7] = '{8'h80, 8'h7F, 24'h000000, 16'hC080, 16'hC080, 1'b0};

    // Clock/reset
    reset = 1'b1; active = 1'b0; wwrite = 1'b0; wswap = 1'b0; ovf_clr = 1'b0;
    datain = '0; win = '0; sumin = '0;
    repeat (2) @(posedge clock);
    #1;
    check_all_zero("init");
    reset = 1'b0;
    model_init();

    // Arithmetic table on the 16-bit saturating and wrapping instances
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h0, 24'h0, 1'b1, vecs[i].w, 1'b0, 1'b1);
      step(1'b0, 8'h0, 24'h0, 1'b0, 8'h0, 1'b1, 1'b0);
      step(1'b1, vecs[i].d, vecs[i].s, 1'b0, 8'h0, 1'b0, 1'b0);
      check("vec_sat", 24'(if_s.maccout), 24'(vecs[i].exp_sat));
      check("vec_wrap", 24'(if_w.maccout), 24'(vecs[i].exp_wrap));
      check("vec_ovf_sat", 24'(if_s.ovf), 24'(vecs[i].ovf));
      check("vec_ovf_wrap", 24'(if_w.ovf), 24'(vecs[i].ovf));
    end

    // Overflow and clear on the same edge: set wins, later clear drops it
    step(1'b0, 8'h0, 24'h0, 1'b1, 8'h80, 1'b0, 1'b1);
    step(1'b0, 8'h0, 24'h0, 1'b0, 8'h0, 1'b1, 1'b0);
    step(1'b1, 8'h80, 24'h007FFF, 1'b0, 8'h0, 1'b0, 1'b1);
    check("ovf_set_wins", 24'(if_s.ovf), 24'h1);
    step(1'b0, 8'h0, 24'h0, 1'b0, 8'h0, 1'b0, 1'b1);
    check("ovf_clr", 24'(if_s.ovf), 24'h0);

    // Load/swap from a clean reset, then latency sweep
    reset = 1'b1;
    #1;
    reset = 1'b0;
    model_init();
    step(1'b0, 8'h0, 24'h0, 1'b1, 8'd5, 1'b0, 1'b0);
    check("load_wout_first", 24'(if_l1.wout), 24'h0);
    step(1'b0, 8'h0, 24'h0, 1'b1, 8'd7, 1'b0, 1'b0);
    check("load_wout_second", 24'(if_l1.wout), 24'd5);
    step(1'b0, 8'h0, 24'h0, 1'b0, 8'h0, 1'b1, 1'b0);
    shot(8'd3, 24'd10, 24'd31);
    step(1'b0, 8'h0, 24'h0, 1'b1, 8'd4, 1'b0, 1'b0);
    step(1'b0, 8'h0, 24'h0, 1'b0, 8'h0, 1'b1, 1'b0);
    shot(8'd2, 24'd1, 24'd9);

    // Write and swap on the same edge
    step(1'b0, 8'h0, 24'h0, 1'b1, 8'd5, 1'b0, 1'b0);
    step(1'b0, 8'h0, 24'h0, 1'b1, 8'd9, 1'b1, 1'b0);
    shot(8'd1, 24'd0, 24'd5);
    step(1'b0, 8'h0, 24'h0, 1'b0, 8'h0, 1'b1, 1'b0);
    shot(8'd1, 24'd0, 24'd9);

    // Stall for 3 cycles between the second and third issue
    step(1'b0, 8'h0, 24'h0, 1'b1, 8'd3, 1'b0, 1'b0);
    step(1'b0, 8'h0, 24'h0, 1'b0, 8'h0, 1'b1, 1'b0);
    step(1'b1, 8'd1, 24'd100, 1'b0, 8'h0, 1'b0, 1'b0);
    step(1'b1, 8'd2, 24'd200, 1'b0, 8'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'($urandom), 24'($urandom), 1'b0, 8'h0, 1'b0, 1'b0);
      check("stall_dataout", 24'(if_l1.dataout), 24'd2);
      check("stall_activeout", 24'(if_l1.activeout), 24'h0);
    end
    step(1'b1, 8'd3, 24'd300, 1'b0, 8'h0, 1'b0, 1'b0);
    check("stall_resume_l1", if_l1.maccout, 24'd309);
    step(1'b1, 8'd4, 24'd400, 1'b0, 8'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'h0, 24'h0, 1'b0, 8'h0, 1'b0, 1'b0);

    // Random stream with weight reloads, swaps in flight, stalls and clears
    for (int i = 0; i < 150; i++) rand_step();

    // Asynchronous reset between edges, mid-stream
    step(1'b1, 8'h55, 24'h001234, 1'b1, 8'h66, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_rst");
    #1;
    reset = 1'b0;
    model_init();
    step(1'b1, 8'd5, 24'd77, 1'b0, 8'h0, 1'b0, 1'b0);
    check("post_rst_weight0", if_l1.maccout, 24'd77);
    for (int i = 0; i < 20; i++) rand_step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_dbw.md
Name: pe_dbw

Overview:
- Parametrised successor to the int8 systolic processing element.
- Performs one signed multiply-accumulate per cycle: maccout = sumin + datain * weight.
- Adds configurable data/weight/accumulator widths and a pipelined multiplier of selectable latency.
- Adds a double-buffered weight: the next tile's weights shift in while the current tile computes, then swap on a propagated strobe.
- Adds optional saturation with a sticky overflow flag. Instantiated as one tile of the matrix-multiply array.

Parameters:
- DATA_W, 8, datain/dataout width (signed).
- WEIGHT_W, 8, weight width (signed).
- ACC_W, 24, sumin/maccout width (signed). Must be >= DATA_W+WEIGHT_W; elaboration error otherwise.
- MULT_LAT, 1, multiply-accumulate pipeline depth, legal 1..3.
- SATURATE, 1, 1 = clamp on overflow, 0 = two's-complement wrap.

Ports:
- clock  in  1  global clock.
- reset  in  1  asynchronous, active-high reset.
- active  in  1  pipeline enable; 0 = stall.
- datain  in  DATA_W  activation from the left neighbour.
- win  in  WEIGHT_W  weight shift-chain input.
- wwrite  in  1  shift win into the shadow weight.
- wswap  in  1  copy the shadow weight into the active weight.
- sumin  in  ACC_W  partial sum from the upper neighbour.
- ovf_clr  in  1  clears ovf.
- maccout  out  ACC_W  sumin + datain*weight.
- dataout  out  DATA_W  datain delayed 1 cycle (to the right neighbour).
- wout  out  WEIGHT_W  previous shadow weight (to the downstream chain).
- wwriteout  out  1  wwrite delayed 1 cycle.
- wswapout  out  1  wswap delayed 1 cycle.
- activeout  out  1  active delayed 1 cycle.
- ovf  out  1  sticky overflow flag.

Behaviour:
- Reset: asynchronous, effective immediately on assertion. The following all clear to 0:
  - all outputs;
  - shadow weight and active weight;
  - every pipeline stage.
- No state survives a reset asserted mid-operation; in-flight products are discarded.
- Weight chain (independent of active):
  - On an edge with wwrite=1: shadow <= win and wout <= old shadow; otherwise wout <= 0.
  - wwriteout <= wwrite every edge. An N-deep column is loaded by N consecutive wwrite cycles, last weight first.
- Swap:
  - On an edge with wswap=1: active_w <= shadow. wswapout <= wswap every edge, which gives diagonal propagation.
  - wwrite and wswap on the same edge: active_w takes the pre-write shadow and shadow takes win.
  - A swap does not disturb products already in flight; they keep the weight sampled at issue.
- MAC pipeline, enabled by active:
  - Stage 0 captures datain, sumin and active_w.
  - maccout updates MULT_LAT enabled edges after issue.
- Arithmetic:
  - Product: full DATA_W+WEIGHT_W signed, sign-extended.
  - Sum: computed at ACC_W+1 bits.
  - Overflow: the sum falls outside the ACC_W signed range.
    - SATURATE=1: clamp to 2^(ACC_W-1)-1 or -2^(ACC_W-1).
    - SATURATE=0: keep the low ACC_W bits.
  - In both modes, overflow sets ovf.
- ovf clearing: ovf stays set until ovf_clr=1 (synchronous) or reset. If overflow and ovf_clr occur on the same edge, ovf=1 (set wins).
- Stall (active=0):
  - All MAC stages, maccout and dataout hold their values.
  - Nothing is lost or duplicated across a stall.
  - activeout still tracks active with 1-cycle delay.
  - The weight chain and swap keep running during a stall.
- dataout: registered datain with 1-cycle latency, updated only on active edges. Its latency is independent of MULT_LAT.

Decomposition:
- Package pe_pkg holds:
  - default width constants (PE_DATA_W=8, PE_WEIGHT_W=8, PE_ACC_W=24);
  - a sat_add function (operands, width, saturate flag → result and overflow bit).
- One sub-module: pe_mac_pipe. It contains the signed multiply, the add, and MULT_LAT enable-gated stages, and outputs the sum plus the overflow bit.
- pe_dbw itself holds the weight buffers, the pass-through registers and ovf.

Test Plan:
1. Reset: run a stream, then assert reset asynchronously between edges -> all outputs 0 before the next edge; the first result after release uses weight 0 (maccout = sumin).
2. Load/swap: wwrite with win=5 then win=7 -> wout shows 0 then 5. Then wswap, followed by active with datain=3, sumin=10 -> maccout=31 after MULT_LAT edges.
3. Saturation (ACC_W=16, SATURATE=1): weight=-128, datain=-128, sumin=32767 -> maccout=32767, ovf=1. With SATURATE=0 -> maccout=-16385, ovf=1. Then ovf_clr -> ovf=0.
4. Stall: issue datain 1,2,3,4 and drop active for 3 cycles after the second -> maccout/dataout frozen; after resume, results appear in order with no gaps or repeats; activeout shows a 3-cycle low.
5. Simultaneous load/swap: shadow=5, then wwrite with win=9 and wswap on the same edge -> active weight 5, shadow 9; a later swap gives active weight 9.
6. Latency sweep MULT_LAT=1,2,3: single-shot datain=2, weight=4, sumin=1 -> maccout=9 exactly 1/2/3 edges after issue; dataout always after 1 edge.
